// File: rtl/pds_arb_pkg.sv
// Shared types and constants for the 4-way round-robin line arbiter.
package pds_arb_pkg;

  localparam int unsigned N_ZAHT = 4;
  localparam int unsigned ADR_W  = 2;

  // Idle, grant active, dead gap between grants.
  typedef enum logic [1:0] {
    StMiruj   = 2'd0,
    StDodjela = 2'd1,
    StPauza   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mux4_rr_arbitar_if.sv
// Request/grant/data bundle between the four requesters and the arbiter.
interface mux4_rr_arbitar_if;
  import pds_arb_pkg::*;

  logic [N_ZAHT-1:0] zaht;
  logic [N_ZAHT-1:0] inf_ul;
  logic [N_ZAHT-1:0] dozv;
  logic [ADR_W-1:0]  adr_ul;
  logic              aktivan;
  logic              inf_izl;

  modport master (
    output zaht,
    output inf_ul,
    input  dozv,
    input  adr_ul,
    input  aktivan,
    input  inf_izl
  );

  modport slave (
    input  zaht,
    input  inf_ul,
    output dozv,
    output adr_ul,
    output aktivan,
    output inf_izl
  );

endinterface

// File: rtl/rr_odabir.sv
// Combinational round-robin picker: first set request after the last-served index.
module rr_odabir
  import pds_arb_pkg::*;
(
  input  logic [N_ZAHT-1:0] zaht,
  input  logic [ADR_W-1:0]  zadnji,
  output logic              valid,
  output logic [ADR_W-1:0]  pick
);

  logic [ADR_W-1:0] idx;

  // Scan zadnji+1 .. zadnji+4 (mod 4); the last step wraps back to zadnji itself.
  always_comb begin
    valid = 1'b0;
    pick  = zadnji;
    idx   = zadnji;
    for (int k = 1; k <= N_ZAHT; k++) begin
      idx = zadnji + ADR_W'(k);
      if (!valid && zaht[idx]) begin
        valid = 1'b1;
        pick  = idx;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbitar.sv
// Round-robin arbiter for a shared 4:1 single-bit line with burst limit and dead gap.
module mux4_rr_arbitar
  import pds_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST  = 8,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  mux4_rr_arbitar_if.slave   bus
);

  localparam logic [7:0] BurstMax = 8'(MAX_BURST);
  localparam logic [3:0] GapMax   = 4'(GAP_CYCLES);

  arb_state_e        state_q, state_d;
  logic [N_ZAHT-1:0] dozv_q, dozv_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [ADR_W-1:0]  zadnji_q, zadnji_d;
  logic [7:0]        brojac_q, brojac_d;
  logic [3:0]        gap_q, gap_d;
  logic              aktivan_q, aktivan_d;

  logic             pick_valid;
  logic [ADR_W-1:0] pick;
  logic             release_grant;
  logic             gap_done;

  rr_odabir u_odabir (
    .zaht   (bus.zaht),
    .zadnji (zadnji_q),
    .valid  (pick_valid),
    .pick   (pick)
  );

  assign release_grant = !bus.zaht[adr_q] || (brojac_q == BurstMax);
  assign gap_done      = (gap_q == GapMax);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StMiruj;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StMiruj:   if (pick_valid) state_d = StDodjela;
      StDodjela: if (release_grant) state_d = StPauza;
      StPauza:   if (gap_done) state_d = pick_valid ? StDodjela : StMiruj;
      default:   state_d = StMiruj;
    endcase
  end

  // Grant, pointer and counter updates for each transition.
  always_comb begin
    dozv_d    = dozv_q;
    adr_d     = adr_q;
    zadnji_d  = zadnji_q;
    brojac_d  = brojac_q;
    gap_d     = gap_q;
    aktivan_d = aktivan_q;
    unique case (state_q)
      StMiruj: begin
        if (pick_valid) begin
          dozv_d    = N_ZAHT'(1) << pick;
          adr_d     = pick;
          aktivan_d = 1'b1;
          brojac_d  = 8'd1;
        end
      end
      StDodjela: begin
        if (release_grant) begin
          dozv_d    = '0;
          aktivan_d = 1'b0;
          zadnji_d  = adr_q;
          gap_d     = 4'd1;
        end else begin
          brojac_d = brojac_q + 8'd1;
        end
      end
      StPauza: begin
        gap_d = gap_q + 4'd1;
        if (gap_done) begin
          gap_d = '0;
          if (pick_valid) begin
            dozv_d    = N_ZAHT'(1) << pick;
            adr_d     = pick;
            aktivan_d = 1'b1;
            brojac_d  = 8'd1;
          end
        end
      end
      default: begin
        dozv_d    = '0;
        aktivan_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; zadnji resets to 3 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      dozv_q    <= '0;
      adr_q     <= '0;
      zadnji_q  <= 2'd3;
      brojac_q  <= '0;
      gap_q     <= '0;
      aktivan_q <= 1'b0;
    end else begin
      dozv_q    <= dozv_d;
      adr_q     <= adr_d;
      zadnji_q  <= zadnji_d;
      brojac_q  <= brojac_d;
      gap_q     <= gap_d;
      aktivan_q <= aktivan_d;
    end
  end

  assign bus.dozv    = dozv_q;
  assign bus.adr_ul  = adr_q;
  assign bus.aktivan = aktivan_q;
  assign bus.inf_izl = aktivan_q & bus.inf_ul[adr_q];

  a_dozv_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(dozv_q));
  a_aktivan:     assert property (@(posedge clk) disable iff (rst) aktivan_q == |dozv_q);
  a_adr_match:   assert property (@(posedge clk) disable iff (rst)
                                  (dozv_q != '0) |-> dozv_q[adr_q]);

endmodule

// File: tb/tb_mux4_rr_arbitar.sv
// Directed bench: default-parameter instance (a) and a MAX_BURST=4 instance (b).
module tb_mux4_rr_arbitar;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] zaht = 4'b0000;
  logic [3:0] inf_ul = 4'b0000;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux4_rr_arbitar_if u_if_a ();
  mux4_rr_arbitar_if u_if_b ();

  assign u_if_a.zaht   = zaht;
  assign u_if_a.inf_ul = inf_ul;
  assign u_if_b.zaht   = zaht;
  assign u_if_b.inf_ul = inf_ul;

  mux4_rr_arbitar u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (u_if_a)
  );

  mux4_rr_arbitar #(
    .MAX_BURST  (4),
    .GAP_CYCLES (1)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (u_if_b)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    zaht = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // 1. Reset held with all requests asserted.
    rst    = 1'b1;
    zaht   = 4'b1111;
    inf_ul = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("rst_dozv", 8'(u_if_a.dozv), 8'h00);
      check_eq("rst_adr", 8'(u_if_a.adr_ul), 8'h00);
      check_eq("rst_akt", 8'(u_if_a.aktivan), 8'h00);
      check_eq("rst_izl", 8'(u_if_a.inf_izl), 8'h00);
    end
    zaht = 4'b0000;
    rst  = 1'b0;
    step();
    check_eq("idle_dozv", 8'(u_if_a.dozv), 8'h00);

    // 2. Single requester 1, held three edges then dropped.
    zaht = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      step();
      check_eq("single_dozv", 8'(u_if_a.dozv), 8'h02);
      check_eq("single_adr", 8'(u_if_a.adr_ul), 8'h01);
    end
    zaht = 4'b0000;
    check_eq("single_trail", 8'(u_if_a.dozv), 8'h02);
    step();
    check_eq("single_rel_dozv", 8'(u_if_a.dozv), 8'h00);
    check_eq("single_rel_akt", 8'(u_if_a.aktivan), 8'h00);
    check_eq("single_rel_adr", 8'(u_if_a.adr_ul), 8'h01);
    step();
    check_eq("single_idle_adr", 8'(u_if_a.adr_ul), 8'h01);
    check_eq("single_idle_dozv", 8'(u_if_a.dozv), 8'h00);

    // 3. Burst limit 4 and full rotation on instance b.
    do_reset();
    zaht = 4'b1111;
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      for (int g = 0; g < 5; g++) begin
        for (int c = 0; c < 4; c++) begin
          step();
          check_eq("rot_dozv", 8'(u_if_b.dozv), 8'(1 << order[g]));
          check_eq("rot_adr", 8'(u_if_b.adr_ul), 8'(order[g]));
        end
        step();
        check_eq("rot_gap", 8'(u_if_b.dozv), 8'h00);
      end
    end

    // 4. Fairness between 0 and 3 with default burst of 8 on instance a.
    do_reset();
    zaht = 4'b1001;
    begin
      int order [4] = '{0, 3, 0, 3};
      for (int g = 0; g < 4; g++) begin
        for (int c = 0; c < 8; c++) begin
          step();
          check_eq("fair_dozv", 8'(u_if_a.dozv), 8'(1 << order[g]));
        end
        step();
        check_eq("fair_gap", 8'(u_if_a.dozv), 8'h00);
        check_eq("fair_gap_akt", 8'(u_if_a.aktivan), 8'h00);
      end
    end

    // 5. Data path through the selected source.
    do_reset();
    zaht   = 4'b0100;
    inf_ul = 4'b0100;
    step();
    check_eq("data_dozv", 8'(u_if_a.dozv), 8'h04);
    check_eq("data_hi", 8'(u_if_a.inf_izl), 8'h01);
    inf_ul = 4'b1011;
    #1;
    check_eq("data_lo", 8'(u_if_a.inf_izl), 8'h00);
    zaht   = 4'b0000;
    inf_ul = 4'b1111;
    #1;
    check_eq("data_trail", 8'(u_if_a.inf_izl), 8'h01);
    step();
    check_eq("data_gap_dozv", 8'(u_if_a.dozv), 8'h00);
    check_eq("data_gap_izl", 8'(u_if_a.inf_izl), 8'h00);
    check_eq("data_gap_adr", 8'(u_if_a.adr_ul), 8'h02);

    // 6. Reset in the middle of a grant to requester 3.
    do_reset();
    zaht = 4'b1000;
    step();
    check_eq("mid_grant3", 8'(u_if_a.dozv), 8'h08);
    check_eq("mid_adr3", 8'(u_if_a.adr_ul), 8'h03);
    step();
    check_eq("mid_hold3", 8'(u_if_a.dozv), 8'h08);
    rst  = 1'b1;
    zaht = 4'b1111;
    step();
    check_eq("mid_rst_dozv", 8'(u_if_a.dozv), 8'h00);
    check_eq("mid_rst_adr", 8'(u_if_a.adr_ul), 8'h00);
    check_eq("mid_rst_akt", 8'(u_if_a.aktivan), 8'h00);
    check_eq("mid_rst_izl", 8'(u_if_a.inf_izl), 8'h00);
    rst = 1'b0;
    step();
    check_eq("post_rst_dozv", 8'(u_if_a.dozv), 8'h01);
    check_eq("post_rst_adr", 8'(u_if_a.adr_ul), 8'h00);
    check_eq("post_rst_akt", 8'(u_if_a.aktivan), 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbitar.md
Name: mux4_rr_arbitar

Overview:
Round-robin arbiter that shares one 4:1 single-bit selection path among four requesters. It accepts requests from up to four sources, grants exactly one at a time, and drives the 2-bit mux address and the selected data bit. Each grant lasts at most MAX_BURST cycles. A mandatory dead gap separates consecutive grants, so two tristate drivers never overlap on the shared line during a handover.

Parameters:
MAX_BURST, 8, maximum consecutive cycles one grant may hold the line (legal range 1..255)
GAP_CYCLES, 1, number of dead cycles with no grant between two grants (legal range 1..15)

Ports:
clk      input   1  system clock; all state updates on its rising edge
rst      input   1  synchronous active-high reset
zaht     input   4  request vector; bit i = requester i wants the line
inf_ul   input   4  data bits from the four sources
dozv     output  4  one-hot grant, registered; 0000 when no grant
adr_ul   output  2  registered mux select = index of the current or most recent grantee
aktivan  output  1  registered; 1 while a grant is active (equals |dozv)
inf_izl  output  1  combinational: aktivan ? inf_ul[adr_ul] : 0

Behaviour:
- Reset (rst=1 at an edge) forces the following values:
  - state = MIRUJ
  - dozv = 0000, adr_ul = 00, aktivan = 0, inf_izl = 0
  - zadnji (last-served pointer) = 3, so requester 0 has first priority
  - brojac = 0, gap counter = 0
- Reset has priority over every other event, including mid-grant and mid-gap. The values above apply from the next edge.
- Round-robin pick: scan indices (zadnji+1), (zadnji+2), (zadnji+3), zadnji, all mod 4. Take the first index with zaht set.
- States: MIRUJ (idle), DODJELA (grant), PAUZA (gap).
- MIRUJ:
  - if zaht != 0 at an edge: go to DODJELA; dozv = onehot(pick), adr_ul = pick, aktivan = 1, brojac = 1.
  - Request-to-grant latency is therefore 1 cycle.
- DODJELA, with g = the current grantee. Release happens at an edge where zaht[g] == 0 OR brojac == MAX_BURST. On release:
  - go to PAUZA; dozv = 0000, aktivan = 0, zadnji = g
  - gap counter = 1; adr_ul holds g
- DODJELA otherwise: brojac increments and the grant holds. Consequences:
  - a continuously held request gets exactly MAX_BURST grant cycles
  - a dropped request keeps dozv high for the cycle in which the drop is sampled; requesters must tolerate this one trailing cycle.
- PAUZA:
  - each edge increments the gap counter.
  - At the edge where gap counter == GAP_CYCLES:
    - if zaht != 0: go directly to DODJELA with a fresh pick (updated zadnji), brojac = 1
    - else: go to MIRUJ
  - The dead time between grants is therefore exactly GAP_CYCLES cycles.
- Changes on zaht bits other than the grantee's have no effect during DODJELA or PAUZA.
- A sole requester is re-granted after the gap; the pick wraps to itself.
- brojac width is 8 bits; it never exceeds MAX_BURST, so there is no wrap.
- Invariants, to be checked by assertions:
  - dozv is always zero or one-hot
  - aktivan == |dozv
  - dozv[i] implies adr_ul == i

Decomposition:
- Shared package pds_arb_pkg holds:
  - state enum {MIRUJ, DODJELA, PAUZA}
  - constants N_ZAHT = 4 and ADR_W = 2
- One natural sub-module, rr_odabir: purely combinational round-robin picker.
  - inputs: zaht[3:0], zadnji[1:0]
  - outputs: valid, pick[1:0]
- FSM, counters and the output mux live in the top module.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with zaht=1111 -> dozv=0000, adr_ul=00, aktivan=0, inf_izl=0 throughout.
2. Single requester: zaht=0010 raised at cycle 0 and held 3 cycles, then dropped -> dozv=0010 and adr_ul=01 from cycle 1. dozv returns to 0000 at the edge after the drop is sampled. adr_ul stays 01 afterwards.
3. Burst limit and rotation: MAX_BURST=4, GAP_CYCLES=1, zaht=1111 held -> grant order 0,1,2,3,0. Each grant lasts exactly 4 cycles, separated by exactly 1 cycle of dozv=0000.
4. Fairness: zaht=1001 held, defaults -> grants alternate 0,3,0,3, each 8 cycles long with a 1-cycle gap. Requester 0 is never granted twice in a row.
5. Data path: grant requester 2 with inf_ul=0100 -> inf_izl=1. Change inf_ul to 1011 -> inf_izl=0. During a gap with inf_ul=1111 -> inf_izl=0.
6. Reset mid-grant: during a grant to 3, assert rst for 1 cycle -> all outputs return to reset values. With zaht=1111 afterwards, the first grant goes to 0, one cycle after rst falls.
